// File: rtl/sevseg_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment driver.
// Segment patterns are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the outputs.
package sevseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // Hex glyphs, index 15 (F) first down to index 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [7:0] AN_OFF  = 8'h00;

  // XOR mask that turns active-high logic levels into pin levels.
  function automatic logic [7:0] pol_mask(input logic active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sevseg_scan_mux_hex.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_sevenseg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevseg_scan_mux.sv
// N-digit multiplexed seven-segment driver with blanking dead-time, PWM brightness,
// leading-zero suppression, per-digit mask and per-frame input snapshot.
module sevseg_scan_mux
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 8192,
  parameter int BLANK_TICKS     = 64,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit AN_ACTIVE_LOW   = 1'b1,
  localparam int IDX_W = clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int               CNT_W     = clog2(TICKS_PER_DIGIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_TICKS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       SEG_POL   = pol_mask(SEG_ACTIVE_LOW);
  localparam logic [7:0]       AN_POL    = pol_mask(AN_ACTIVE_LOW);

  scan_state_t             state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic                    wrap, wrap_next;
  logic                    en_prev;
  logic                    snap_load;
  logic [4*NUM_DIGITS-1:0] snap_value;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_mask;
  logic                    snap_lz;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    lead_zero;
  logic [3:0]              nibble;
  logic [6:0]              seg_hex;
  logic                    pwm_on;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      idx     <= '0;
      wrap    <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      wrap    <= wrap_next;
      en_prev <= en;
    end
  end

  always_comb begin
    cnt_next   = cnt;
    idx_next   = idx;
    state_next = state;
    wrap_next  = 1'b0;
    if (!en) begin
      cnt_next   = '0;
      idx_next   = '0;
      state_next = ST_BLANK;
    end else if (cnt == CNT_LAST) begin
      cnt_next   = '0;
      state_next = ST_BLANK;
      wrap_next  = (idx == IDX_LAST);
      idx_next   = wrap_next ? '0 : idx + IDX_W'(1);
    end else begin
      cnt_next = cnt + CNT_W'(1);
      case (state)
        ST_BLANK: state_next = (cnt_next >= BLANK_END) ? ST_ON : ST_BLANK;
        ST_ON:    state_next = ST_ON;
        default:  state_next = ST_BLANK;
      endcase
    end
  end

  // Display inputs are frozen for a whole frame so a frame never mixes two values.
  assign snap_load = en & (~en_prev | wrap_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_value <= '0;
      snap_dp    <= '0;
      snap_mask  <= '0;
      snap_lz    <= 1'b0;
    end else if (snap_load) begin
      snap_value <= value;
      snap_dp    <= dp_in;
      snap_mask  <= digit_mask;
      snap_lz    <= lz_suppress;
    end
  end

  always_comb begin
    lead_zero = 1'b1;
    suppress  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero   = lead_zero & (snap_value[4*i +: 4] == 4'h0);
      suppress[i] = snap_lz & lead_zero & (i > 0);
    end
  end

  assign nibble = snap_value[{idx, 2'b00} +: 4];
  assign pwm_on = (brightness == 4'hF) | (cnt[3:0] < brightness);

  hex_to_sevenseg u_hex (
    .nibble (nibble),
    .seg    (seg_hex)
  );

  always_comb begin
    an_next  = AN_OFF[NUM_DIGITS-1:0];
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    if (en && (state == ST_ON)) begin
      seg_next = seg_hex;
      dp_next  = snap_dp[idx] & ~suppress[idx];
      if (snap_mask[idx] && !suppress[idx] && pwm_on) begin
        an_next[idx] = 1'b1;
      end else begin
        an_next = AN_OFF[NUM_DIGITS-1:0];
      end
    end else begin
      seg_next = SEG_OFF;
    end
  end

  // Pin register: polarity is applied here so nothing combinational reaches the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_POL[NUM_DIGITS-1:0];
      seg        <= SEG_POL[6:0];
      dp         <= SEG_POL[7];
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next ^ AN_POL[NUM_DIGITS-1:0];
      seg        <= seg_next ^ SEG_POL[6:0];
      dp         <= dp_next ^ SEG_POL[7];
      digit_idx  <= en ? idx : '0;
      frame_tick <= en & wrap;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// Self-checking bench for sevseg_scan_mux (4 digits, 32-cycle slots, 4 blank cycles, active-low pins).
module tb_sevseg_scan_mux;

  localparam int N = 4;
  localparam int T = 32;
  localparam int B = 4;

  localparam logic [3:0] T1_AN  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] T1_SEG [4] = '{7'h02, 7'h40, 7'h0E, 7'h08};
  localparam logic [3:0] T2_AN  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
  localparam logic [6:0] T2_SEG [4] = '{7'h40, 7'h12, 7'h40, 7'h40};

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_mask;
  logic        lz_suppress;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int checks;
  int errors;

  // Reference model state: time since scanning (re)started and the frozen frame inputs.
  int          m_t;
  bit          m_run;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  logic        m_lz;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [1:0]  e_idx;
  logic        e_ft;

  sevseg_scan_mux #(
    .NUM_DIGITS      (4),
    .TICKS_PER_DIGIT (32),
    .BLANK_TICKS     (4),
    .SEG_ACTIVE_LOW  (1'b1),
    .AN_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .value       (value),
    .dp_in       (dp_in),
    .digit_mask  (digit_mask),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .digit_idx   (digit_idx),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Pin levels {an, seg, dp, idx} for scan time t, from the display rules directly.
  function automatic logic [13:0] model_out(input int t, input logic [3:0] br);
    int         cnt;
    int         d;
    bit         supp;
    bit         lit;
    bit         pwm;
    logic [3:0] an_h;
    logic [6:0] seg_h;
    logic       dp_h;
    cnt   = t % T;
    d     = (t / T) % N;
    supp  = m_lz && (d > 0) && ((m_val >> (4 * d)) == 16'h0);
    lit   = cnt >= B;
    pwm   = (br == 4'd15) || ((cnt % 16) < int'(br));
    an_h  = 4'h0;
    if (lit && m_mask[d] && !supp && pwm) an_h[d] = 1'b1;
    seg_h = lit ? hex7(m_val[4*d +: 4]) : 7'h00;
    dp_h  = lit && m_dp[d] && !supp;
    return {~an_h, ~seg_h, ~dp_h, 2'(d)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0; m_run <= 1'b0;
      m_val <= 16'h0; m_dp <= 4'h0; m_mask <= 4'h0; m_lz <= 1'b0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_idx <= 2'd0; e_ft <= 1'b0;
    end else if (!en) begin
      m_t <= 0; m_run <= 1'b0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_idx <= 2'd0; e_ft <= 1'b0;
    end else begin
      {e_an, e_seg, e_dp, e_idx} <= model_out(m_t, brightness);
      e_ft <= (m_t > 0) && ((m_t % (N * T)) == 0);
      if (!m_run || (((m_t + 1) % (N * T)) == 0)) begin
        m_val <= value; m_dp <= dp_in; m_mask <= digit_mask; m_lz <= lz_suppress;
      end
      m_t   <= m_t + 1;
      m_run <= 1'b1;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({an, seg, dp, digit_idx, frame_tick} !== {e_an, e_seg, e_dp, e_idx, e_ft}) begin
      errors++;
      $display("FAIL model @%0t got an=%b seg=%h dp=%b idx=%0d ft=%b want an=%b seg=%h dp=%b idx=%0d ft=%b",
               $time, an, seg, dp, digit_idx, frame_tick, e_an, e_seg, e_dp, e_idx, e_ft);
    end
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("FAIL onehot @%0t got an=%b want at most one low", $time, an);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 400);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout @%0t got no frame_tick in %0d cycles want one", $time, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @%0t got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int act;
    rst = 1'b1; en = 1'b0; value = 16'h0; dp_in = 4'h0;
    digit_mask = 4'hF; lz_suppress = 1'b0; brightness = 4'hF;
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    rst = 1'b0;

    // Basic scan order, glyphs, blanking and frame period.
    value = 16'hAF06; dp_in = 4'b0001; en = 1'b1;
    wait_tick(n);
    for (int d = 0; d < 4; d++) begin
      repeat (d == 0 ? 4 : 32) @(negedge clk);
      chk("t1_an", 32'(an), 32'(T1_AN[d]));
      chk("t1_seg", 32'(seg), 32'(T1_SEG[d]));
      chk("t1_dp", 32'(dp), (d == 0) ? 32'h0 : 32'h1);
    end
    wait_tick(n);
    wait_tick(n);
    chk("t1_period", 32'(n), 32'd128);

    // Leading-zero suppression.
    value = 16'h0050; lz_suppress = 1'b1; dp_in = 4'h0;
    wait_tick(n);
    for (int d = 0; d < 4; d++) begin
      repeat (d == 0 ? 4 : 32) @(negedge clk);
      chk("t2_an", 32'(an), 32'(T2_AN[d]));
      chk("t2_seg", 32'(seg), 32'(T2_SEG[d]));
    end
    value = 16'h0000;
    wait_tick(n);
    for (int d = 0; d < 4; d++) begin
      repeat (d == 0 ? 4 : 32) @(negedge clk);
      chk("t2z_an", 32'(an), (d == 0) ? 32'hE : 32'hF);
    end

    // PWM brightness.
    value = 16'h1234; lz_suppress = 1'b0; brightness = 4'd4;
    wait_tick(n);
    repeat (4) @(negedge clk);
    chk("t3_c4", 32'(an), 32'hF);
    repeat (12) @(negedge clk);
    chk("t3_c16", 32'(an), 32'hE);
    repeat (3) @(negedge clk);
    chk("t3_c19", 32'(an), 32'hE);
    repeat (1) @(negedge clk);
    chk("t3_c20", 32'(an), 32'hF);
    brightness = 4'd0;
    wait_tick(n);
    wait_tick(n);
    chk("t3_dark_period", 32'(n), 32'd128);

    // Mid-frame value change stays hidden until the next frame.
    brightness = 4'hF;
    wait_tick(n);
    repeat (72) @(negedge clk);
    value = 16'h5678;
    repeat (32) @(negedge clk);
    chk("t4_old_an", 32'(an), 32'h7);
    chk("t4_old_seg", 32'(seg), 32'h79);
    wait_tick(n);
    repeat (4) @(negedge clk);
    chk("t4_new_an", 32'(an), 32'hE);
    chk("t4_new_seg", 32'(seg), 32'h00);

    // Enable dropped mid-slot.
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t5_off_an", 32'(an), 32'hF);
    chk("t5_off_seg", 32'(seg), 32'h7F);
    repeat (9) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_blank_an", 32'(an), 32'hF);
    chk("t5_idx", 32'(digit_idx), 32'h0);
    @(negedge clk);
    chk("t5_first_an", 32'(an), 32'hE);

    // Asynchronous reset mid-ON.
    repeat (5) @(negedge clk);
    chk("t6_pre_an", 32'(an), 32'hE);
    #2 rst = 1'b1;
    #1;
    chk("t6_an", 32'(an), 32'hF);
    chk("t6_seg", 32'(seg), 32'h7F);
    chk("t6_dp", 32'(dp), 32'h1);
    chk("t6_idx", 32'(digit_idx), 32'h0);
    chk("t6_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 9);
      if (act < 5) begin
        value       = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in       = 4'($urandom);
        digit_mask  = 4'($urandom);
        lz_suppress = 1'($urandom);
      end else if (act < 7) begin
        brightness = 4'($urandom);
      end else if (act < 9) begin
        en = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        en = 1'b1;
      end else begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(20, 300)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
